// File: rtl/mb_pkg.sv
// Shared Modbus stack definitions: event code width and event code values.
// Used by the event scheduler, the poll FSM and the frame timers.
package mb_pkg;

    localparam int EVW = 2;

    typedef logic [EVW-1:0] ev_code_t;

    localparam ev_code_t EV_READY          = 2'd0;
    localparam ev_code_t EV_FRAME_RECEIVED = 2'd1;
    localparam ev_code_t EV_EXECUTE        = 2'd2;
    localparam ev_code_t EV_FRAME_SENT     = 2'd3;

endpackage

// File: rtl/mb_event_sched_if.sv
// Event scheduler bus: poster requests/acks, consumer valid/get, queue status.
// master = stack side (posters + poll FSM), slave = scheduler.
interface mb_event_sched_if
    import mb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]     post_req;
    logic [N_REQ*EVW-1:0] post_event;
    logic [N_REQ-1:0]     post_ack;
    logic                 flush;
    logic                 ev_valid;
    ev_code_t             ev_code;
    logic                 ev_get;
    logic [CW-1:0]        ev_count;
    logic                 overrun;

    modport master (
        output post_req, post_event, flush, ev_get,
        input  post_ack, ev_valid, ev_code, ev_count, overrun
    );

    modport slave (
        input  post_req, post_event, flush, ev_get,
        output post_ack, ev_valid, ev_code, ev_count, overrun
    );

endinterface

// File: rtl/mb_rr_arbiter.sv
// One-hot request arbiter. RR=1 searches from a rotating pointer that moves
// to one past the last winner; RR=0 is fixed priority, lowest index wins.
module mb_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter bit RR    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             advance,
    output logic [N_REQ-1:0] grant
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    // Pick the first asserted request at or after the search start, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = '0;
        grant = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((RR ? (int'(ptr_q) + k) : k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (en && found) begin
            grant[gidx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (advance && found && en) begin
            ptr_d = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Rotating search pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mb_event_sched.sv
// Modbus event scheduler: arbitrates event posts into a DEPTH-entry FIFO and
// presents the oldest event to the poll FSM. Push and pop may coincide even
// when full, so a busy consumer never starves posters.
module mb_event_sched
    import mb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DEPTH = 4,
    parameter bit RR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    mb_event_sched_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_REQ-1:0] grant;
    ev_code_t         push_code;
    logic             full;
    logic             arb_en;
    logic             push;
    logic             pop;
    logic             stalled;

    ev_code_t         mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic             overrun_q, overrun_d;

    // A slot is available when not full, or when the head leaves this cycle.
    // Reset gating keeps post_ack low while the block is held in reset.
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && bus.ev_get && !bus.flush;
    assign arb_en  = rst_n && !bus.flush && (!full || bus.ev_get);
    assign push    = |grant;
    assign stalled = (|bus.post_req) && full && !bus.ev_get;

    mb_rr_arbiter #(
        .N_REQ (N_REQ),
        .RR    (RR)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.post_req),
        .en      (arb_en),
        .advance (push),
        .grant   (grant)
    );

    // Select the winning poster's code; grant is one-hot so OR-ing is exact.
    always_comb begin
        push_code = EV_READY;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                push_code = push_code | bus.post_event[i*EVW +: EVW];
            end
        end
    end

    // Queue pointers, occupancy and overrun detection; flush wins over push/pop.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wait_d    = wait_q;
        overrun_d = overrun_q;
        if (bus.flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            wait_d    = '0;
            overrun_d = 1'b0;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push) begin
                tail_d = tail_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (push) begin
                wait_d = '0;
            end else if (stalled) begin
                if (wait_q != CW'(DEPTH)) begin
                    wait_d = wait_q + 1'b1;
                end
                if (wait_q >= CW'(DEPTH - 1)) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            overrun_q <= overrun_d;
        end
    end

    // Event storage, written at the tail on an accepted post.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= EV_READY;
            end
        end else if (push) begin
            mem_q[tail_q] <= push_code;
        end
    end

    assign bus.post_ack = grant;
    assign bus.ev_valid = (count_q != '0);
    assign bus.ev_code  = (count_q != '0) ? mem_q[head_q] : EV_READY;
    assign bus.ev_count = count_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_mb_event_sched.sv
// Self-checking bench for mb_event_sched: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_mb_event_sched;
    import mb_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mb_event_sched_if #(.N_REQ(N), .DEPTH(D)) bus();

    mb_event_sched #(.N_REQ(N), .DEPTH(D), .RR(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [1:0] mq[$];
    int         m_ptr  = 0;
    int         m_wait = 0;
    bit         m_ovr  = 1'b0;
    logic [N-1:0] last_ack = '0;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Check DUT outputs against the model for the current inputs, then advance the model
    // to the state it must hold after the coming clock edge.
    task automatic model_step();
        int  sz;
        int  w;
        bit  full;
        bit  en;
        int  exp_ack;
        if (!rst_n) begin
            mq.delete();
            m_ptr  = 0;
            m_wait = 0;
            m_ovr  = 1'b0;
            chk("rst ack", int'(bus.post_ack), 0);
            chk("rst valid", int'(bus.ev_valid), 0);
            chk("rst code", int'(bus.ev_code), 0);
            chk("rst count", int'(bus.ev_count), 0);
            chk("rst overrun", int'(bus.overrun), 0);
            last_ack = '0;
            return;
        end
        sz   = mq.size();
        full = (sz == D);
        en   = !bus.flush && (!full || bus.ev_get);
        w    = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && bus.post_req[i]) w = i;
        end
        exp_ack = (en && w >= 0) ? (1 << w) : 0;
        chk("ack", int'(bus.post_ack), exp_ack);
        chk("valid", int'(bus.ev_valid), (sz > 0) ? 1 : 0);
        chk("code", int'(bus.ev_code), (sz > 0) ? int'(mq[0]) : 0);
        chk("count", int'(bus.ev_count), sz);
        chk("overrun", int'(bus.overrun), int'(m_ovr));
        last_ack = bus.post_ack;

        if (bus.flush) begin
            mq.delete();
            m_wait = 0;
            m_ovr  = 1'b0;
        end else begin
            if (sz > 0 && bus.ev_get) void'(mq.pop_front());
            if (exp_ack != 0) begin
                mq.push_back(bus.post_event[w*EVW +: EVW]);
                m_ptr  = (w + 1) % N;
                m_wait = 0;
            end else if ((|bus.post_req) && full && !bus.ev_get) begin
                m_wait++;
                if (m_wait >= D) m_ovr = 1'b1;
            end
        end
    endtask

    // One clock: inputs already driven; check at negedge, resume 1 after posedge.
    // Posters hold their request until acked.
    task automatic do_cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        bus.post_req = bus.post_req & ~last_ack;
    endtask

    initial begin
        logic [1:0] code;
        int         get_pct;
        bus.post_req   = '0;
        bus.post_event = '0;
        bus.flush      = 1'b0;
        bus.ev_get     = 1'b0;

        // Test 1: reset then idle.
        repeat (2) do_cycle();
        rst_n = 1'b1;
        repeat (2) do_cycle();
        chk("t1 valid", int'(bus.ev_valid), 0);
        chk("t1 count", int'(bus.ev_count), 0);
        chk("t1 ack", int'(bus.post_ack), 0);
        chk("t1 code", int'(bus.ev_code), 0);

        // Test 2: single post from poster 2.
        bus.post_event[2*EVW +: EVW] = EV_FRAME_RECEIVED;
        bus.post_req = 4'b0100;
        do_cycle();
        chk("t2 ack", int'(last_ack), 4);
        chk("t2 valid", int'(bus.ev_valid), 1);
        chk("t2 code", int'(bus.ev_code), 1);
        bus.ev_get = 1'b1;
        do_cycle();
        bus.ev_get = 1'b0;
        chk("t2 valid after get", int'(bus.ev_valid), 0);

        // Test 3: four-way collision after a fresh reset (pointer back to 0).
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        do_cycle();
        bus.post_event = 8'b11_10_01_00;
        bus.post_req   = 4'hF;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            chk("t3 ack order", int'(last_ack), 1 << i);
        end
        chk("t3 count", int'(bus.ev_count), 4);
        chk("t3 head", int'(bus.ev_code), 0);

        // Test 4: push and pop together while full.
        bus.post_event[1*EVW +: EVW] = EV_FRAME_SENT;
        bus.post_req = 4'b0010;
        bus.ev_get   = 1'b1;
        do_cycle();
        chk("t4 ack", int'(last_ack), 2);
        chk("t4 count", int'(bus.ev_count), 4);
        chk("t4 head", int'(bus.ev_code), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4 pop order", int'(bus.ev_code), (i < 3) ? i + 1 : 3);
            do_cycle();
        end
        bus.ev_get = 1'b0;
        chk("t4 drained", int'(bus.ev_count), 0);

        // Test 5: overrun after DEPTH stalled cycles, cleared by flush.
        bus.post_event = 8'b11_00_01_10;
        bus.post_req   = 4'hF;
        repeat (4) do_cycle();
        chk("t5 full", int'(bus.ev_count), 4);
        bus.post_req = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            do_cycle();
            chk("t5 overrun", int'(bus.overrun), (c >= 4) ? 1 : 0);
        end
        bus.flush = 1'b1;
        do_cycle();
        bus.flush    = 1'b0;
        bus.post_req = '0;
        chk("t5 flush count", int'(bus.ev_count), 0);
        chk("t5 flush overrun", int'(bus.overrun), 0);

        // Test 6: asynchronous reset with three events queued.
        bus.post_req = 4'hF;
        repeat (3) do_cycle();
        bus.post_req = '0;
        chk("t6 count", int'(bus.ev_count), 3);
        rst_n = 1'b0;
        #1;
        chk("t6 async valid", int'(bus.ev_valid), 0);
        chk("t6 async count", int'(bus.ev_count), 0);
        chk("t6 async code", int'(bus.ev_code), 0);
        do_cycle();
        rst_n = 1'b1;
        repeat (2) do_cycle();
        chk("t6 no stale", int'(bus.ev_valid), 0);

        // Randomized traffic; consumer speed varies per block to reach full/overrun.
        get_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) get_pct = $urandom_range(90, 5);
            for (int i = 0; i < N; i++) begin
                if (!bus.post_req[i] && $urandom_range(2) == 0) begin
                    code = 2'($urandom_range(3));
                    bus.post_event[i*EVW +: EVW] = code;
                    bus.post_req[i] = 1'b1;
                end else if (bus.post_req[i] && $urandom_range(49) == 0) begin
                    bus.post_req[i] = 1'b0;
                end
            end
            bus.ev_get = ($urandom_range(99) < get_pct);
            bus.flush  = ($urandom_range(99) == 0);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(499) == 0) rst_n = 1'b0;
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
